prog_loader: RTL

- Upstream feeder of the instruction memory read by the fetch stage.
- Takes a byte stream from the UART receiver, checks a framed program image, packs bytes into 32-bit little-endian words and writes them into the prgrom write port at word addresses 0..N-1.
- Holds the CPU core in reset while a load is in progress.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_timeout.sv | 28 ++
 rtl/prog_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program loader
package prog_loader_pkg;

  // Instruction-memory word-address width shared by fetch, prgrom and loader
  localparam int unsigned PL_ADDR_W = 14;
  localparam logic [7:0]  PL_MAGIC  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    ERROR
  } state_t;

endpackage

// File: rtl/prog_loader_timeout.sv
// rtl/prog_loader_timeout.sv - inter-byte watchdog for the loader frame
module loader_timeout #(
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Counter saturates at LIMIT; the FSM leaves the frame states on expiry
  always_ff @(posedge clk) begin
    if (!rst || !enable || kick) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - checks a framed UART program image and writes it into instruction memory
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = PL_ADDR_W,
  parameter int unsigned TIMEOUT = 50000000,
  parameter logic [7:0]  MAGIC   = PL_MAGIC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t      state, state_nxt;
  logic [7:0]  cnt_lo;
  logic [16:0] word_cnt;
  logic [16:0] words_seen;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  csum;
  logic        last_pend;
  logic        in_frame;
  logic        tmo_expired;

  logic        start;
  logic        pack;
  logic        word_end;
  logic        csum_ok;
  logic        go_err;

  logic [16:0] n_full;
  logic [16:0] depth;
  logic [16:0] addr_ext;
  logic [7:0]  csum_nxt;

  assign n_full   = {1'b0, rx_data, cnt_lo};
  assign depth    = 17'd1 << ADDR_W;
  assign addr_ext = 17'(prog_addr);
  assign csum_nxt = csum + rx_data;

  assign in_frame = (state == CNT_LO) || (state == CNT_HI) ||
                    (state == DATA)   || (state == CSUM);
  assign cpu_hold = (state != IDLE);
  assign busy     = (state != IDLE) && (state != ERROR);

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (in_frame),
    .kick    (rx_valid),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pack      = 1'b0;
    word_end  = 1'b0;
    csum_ok   = 1'b0;
    go_err    = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (rx_valid && (rx_data == MAGIC)) begin
          start     = 1'b1;
          state_nxt = CNT_LO;
        end
      end
      default: begin
        if (rx_err) begin
          go_err = 1'b1;
        end else if (rx_valid) begin
          case (state)
            CNT_LO: state_nxt = CNT_HI;
            CNT_HI: begin
              if (n_full == 17'd0)     state_nxt = CSUM;
              else if (n_full > depth) go_err    = 1'b1;
              else                     state_nxt = DATA;
            end
            DATA: begin
              // While the final write pulse is out, the next byte is the checksum
              if (last_pend) begin
                if (rx_data == csum) csum_ok = 1'b1;
                else                 go_err  = 1'b1;
              end else begin
                pack     = 1'b1;
                word_end = (byte_idx == 2'd3);
              end
            end
            CSUM: begin
              if (rx_data == csum) csum_ok = 1'b1;
              else                 go_err  = 1'b1;
            end
            default: ;
          endcase
        end else if (tmo_expired) begin
          go_err = 1'b1;
        end else if ((state == DATA) && last_pend) begin
          state_nxt = CSUM;
        end
        if (go_err)  state_nxt = ERROR;
        if (csum_ok) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cnt_lo     <= '0;
      word_cnt   <= '0;
      words_seen <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      last_pend  <= 1'b0;
    end else begin
      prog_we <= word_end;
      if (start) begin
        prog_addr  <= '0;
        done       <= 1'b0;
        err        <= 1'b0;
        cnt_lo     <= '0;
        word_cnt   <= '0;
        words_seen <= '0;
        byte_idx   <= '0;
        csum       <= '0;
      end
      if ((state == CNT_LO) && rx_valid) cnt_lo   <= rx_data;
      if ((state == CNT_HI) && rx_valid) word_cnt <= n_full;
      if (pack) begin
        csum     <= csum_nxt;
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= rx_data;
          2'd1:    word_buf[15:8]  <= rx_data;
          2'd2:    word_buf[23:16] <= rx_data;
          default: ;
        endcase
      end
      if (word_end) begin
        prog_wdata <= {rx_data, word_buf};
        words_seen <= words_seen + 17'd1;
        if ((words_seen + 17'd1) == word_cnt) last_pend <= 1'b1;
      end
      // Address advances after the pulse but stops at the last word
      if (prog_we && ((addr_ext + 17'd1) != word_cnt)) prog_addr <= prog_addr + 1'b1;
      if (state_nxt != DATA) last_pend <= 1'b0;
      if (csum_ok) done <= 1'b1;
      if (go_err)  err  <= 1'b1;
    end
  end

endmodule
